// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and constants for the instruction memory loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] LOADER_CKSUM_INIT = 8'h00;
  localparam int         BYTES_PER_WORD    = 4;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles four bytes into a little-endian 32-bit word
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        last_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0] cnt;

  // Combinational flag: the byte being accepted right now completes a word.
  assign last_byte = byte_valid && (cnt == LAST_IDX);

  // Shift bytes in from the top so the first byte ends up in [7:0]; word_valid
  // pulses the cycle after the fourth byte, when the word register is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte;
      if (byte_valid) begin
        word <= {byte_data, word[31:8]};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams a checksummed program image into instruction memory
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [7:0]    words_loaded
);

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  loader_state_t state, next_state;

  logic       accept;
  logic       start_ok;
  logic       data_byte;
  logic       last_byte;
  logic       word_valid;
  logic [31:0] word;
  logic [7:0] cksum;
  logic [7:0] word_count;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = load_start && ((state == IDLE) || (state == ERR));
  assign data_byte = accept && (state == DATA);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_data  (rx_data),
    .byte_valid (data_byte),
    .last_byte  (last_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  // The write port is driven straight from the packer and the word counter,
  // giving one cycle from the fourth byte to mem_we.
  assign mem_we = word_valid;
  assign wdata  = word;
  assign waddr  = {{(AW-10){1'b0}}, words_loaded, 2'b00};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DATA leaves on the fourth byte of the last word, so the
  // final write lands while already in CSUM and no extra data byte is taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load_start) next_state = HDR;
      HDR: begin
        if (accept) begin
          if ({1'b0, rx_data} > DEPTH_W) next_state = ERR;
          else if (rx_data == 8'd0)      next_state = CSUM;
          else                           next_state = DATA;
        end
      end
      DATA: begin
        if (last_byte && ((words_loaded + 8'd1) == word_count)) next_state = CSUM;
      end
      CSUM: begin
        if (accept) next_state = (rx_data == cksum) ? DONE : ERR;
      end
      DONE:    next_state = IDLE;
      ERR:     if (load_start) next_state = HDR;
      default: next_state = IDLE;
    endcase
  end

  // Header count, running XOR and written-word counter; all restart on a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum        <= LOADER_CKSUM_INIT;
      word_count   <= 8'd0;
      words_loaded <= 8'd0;
    end else if (start_ok) begin
      cksum        <= LOADER_CKSUM_INIT;
      word_count   <= 8'd0;
      words_loaded <= 8'd0;
    end else begin
      if ((state == HDR) && accept) word_count <= rx_data;
      if (data_byte)                cksum <= cksum ^ rx_data;
      if (mem_we)                   words_loaded <= words_loaded + 8'd1;
    end
  end

  // Status outputs registered from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_ready  <= (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
      cpu_hold  <= (next_state != IDLE);
      load_done <= (next_state == DONE);
      load_err  <= (next_state == ERR);
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - table-driven self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_loaded;

  instr_mem_loader #(.DEPTH(64), .AW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bytes;
    int          nbytes;
    bit          gaps;
    int          nwr;
    logic [63:0] w0;
    logic [63:0] w1;
    int          done;
    bit          err;
    int          wl;
    bit          hold;
  } vec_t;

  vec_t vecs[6];

  int          passed = 0;
  int          total = 0;
  logic [63:0] wr_log[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) wr_log.push_back({waddr, wdata});
    if (load_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL accept_timeout: actual rx_ready=0 required byte %0h accepted", b);
      @(posedge clk); #1;
    end
  endtask

  task automatic start_and_check_hold();
    pulse_start();
    @(negedge clk);
    chk("hold_after_start", {cpu_hold, rx_ready}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic check_result(input vec_t v, input int wbase, input int dbase, input string tag);
    int n;
    repeat (3) begin @(posedge clk); #1; end
    n = wr_log.size() - wbase;
    chk({tag, "_writes"}, n, v.nwr);
    if (v.nwr > 0 && n > 0) chk({tag, "_wr0"}, wr_log[wbase], v.w0);
    if (v.nwr > 1 && n > 1) chk({tag, "_wr1"}, wr_log[wbase+1], v.w1);
    chk({tag, "_done_pulses"}, done_cnt - dbase, v.done);
    chk({tag, "_load_err"}, load_err, v.err);
    chk({tag, "_words_loaded"}, words_loaded, v.wl);
    chk({tag, "_cpu_hold"}, cpu_hold, v.hold);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
  endtask

  task automatic run_case(input int idx);
    int wbase;
    int dbase;
    wbase = wr_log.size();
    dbase = done_cnt;
    start_and_check_hold();
    for (int j = 0; j < vecs[idx].nbytes; j++)
      send_byte(vecs[idx].bytes[j*8 +: 8], vecs[idx].gaps ? (j % 6) : 0);
    check_result(vecs[idx], wbase, dbase, $sformatf("vec%0d", idx));
  endtask

  initial begin
    int wbase;
    int dbase;

    // basic two-word load
    vecs[0] = '{96'h0000_C100_1001_1300_5000_9302, 10, 1'b0, 2,
                {32'h0, 32'h00500093}, {32'h4, 32'h00100113}, 1, 1'b0, 2, 1'b0};
    // bad checksum: writes happen, error held
    vecs[1] = '{96'h0000_C000_1001_1300_5000_9302, 10, 1'b0, 2,
                {32'h0, 32'h00500093}, {32'h4, 32'h00100113}, 0, 1'b1, 2, 1'b1};
    // oversize header 65
    vecs[2] = '{96'h41, 1, 1'b0, 0, 64'h0, 64'h0, 0, 1'b1, 0, 1'b1};
    // zero-length image
    vecs[3] = '{96'h0000, 2, 1'b0, 0, 64'h0, 64'h0, 1, 1'b0, 0, 1'b0};
    // one word with rx_valid gaps of 0..5 cycles
    vecs[4] = '{96'h0200_1001_1301, 6, 1'b1, 1,
                {32'h0, 32'h00100113}, 64'h0, 1, 1'b0, 1, 1'b0};
    // same one-word load without gaps
    vecs[5] = '{96'h0200_1001_1301, 6, 1'b0, 1,
                {32'h0, 32'h00100113}, 64'h0, 1, 1'b0, 1, 1'b0};

    #1;
    chk("reset_outputs",
        {rx_ready, mem_we, load_done, load_err, cpu_hold, waddr, wdata, words_loaded}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_case(0);
    run_case(1);
    run_case(0);   // good load after error clears load_err
    run_case(2);
    run_case(3);   // started from ERR
    run_case(4);
    run_case(5);

    // load_start pulsed mid-DATA must not disturb the load
    wbase = wr_log.size();
    dbase = done_cnt;
    start_and_check_hold();
    for (int j = 0; j < vecs[0].nbytes; j++) begin
      if (j == 5) pulse_start();
      send_byte(vecs[0].bytes[j*8 +: 8], 0);
    end
    check_result(vecs[0], wbase, dbase, "ign_start");

    // reset after six data bytes of a two-word load
    wbase = wr_log.size();
    start_and_check_hold();
    for (int j = 0; j < 7; j++) send_byte(vecs[0].bytes[j*8 +: 8], 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {rx_ready, mem_we, load_done, load_err, cpu_hold, waddr, wdata, words_loaded}, 0);
    chk("rst_mid_writes", wr_log.size() - wbase, 1);
    if (wr_log.size() > wbase) chk("rst_mid_wr0", wr_log[wbase], {32'h0, 32'h00500093});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid_idle", {cpu_hold, rx_ready, load_err}, 3'b000);
    chk("rst_mid_no_more_writes", wr_log.size() - wbase, 1);
    run_case(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual time limit reached required $finish");
    $fatal(1);
  end

endmodule
